pipelined_subtractor: RTL and testbench

- Streaming, pipelined WIDTH-bit subtractor computing D = A - B as A + ~B + 1.
- Built from cascaded 4-bit carry-lookahead groups, one group per pipeline stage. The carry is registered between stages and the operands are skewed down the pipe.
- Counterpart to the existing combinational CLA adders in the adder library. It gives the datapath a subtract/compare path with valid/ready flow control and one-result-per-cycle throughput.

---
 rtl/adder_pkg.sv | 32 +++
 rtl/cla4.sv | 35 +++
 rtl/sub_stage.sv | 57 +++++
 rtl/pipelined_subtractor.sv | 131 +++++++++++++
 tb/tb_pipelined_subtractor.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for the pipelined carry-lookahead subtractor.
//
// Contents:
//   GROUP_W     width of one carry-lookahead group; one group per pipe stage
//   MAX_W       widest operand the stage record can carry
//   stages_for  number of pipeline stages (and latency) for a given width
//   stage_t     one pipeline stage record: valid, carry, operand MSBs,
//               accumulated result bits and the not-yet-added operand bits
package adder_pkg;

    localparam int GROUP_W = 4;
    localparam int MAX_W   = 64;

    function automatic int stages_for(input int width);
        return width / GROUP_W;
    endfunction

    // Fields are sized for MAX_W; an instance of WIDTH bits uses the low
    // WIDTH bits of sum and keeps the upper bits of a_rem/nb_rem at zero.
    // a_rem/nb_rem are shifted down one group per stage, so the group a
    // stage works on is always bits [GROUP_W-1:0].
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic             a_msb;   // original A[WIDTH-1], kept for overflow
        logic             b_msb;   // original B[WIDTH-1], kept for overflow
        logic [MAX_W-1:0] sum;     // result bits assembled so far
        logic [MAX_W-1:0] a_rem;   // A bits not yet added
        logic [MAX_W-1:0] nb_rem;  // ~B bits not yet added
    } stage_t;

endpackage

// File: rtl/cla4.sv
// cla4: combinational 4-bit carry-lookahead adder.
//
// Ports:
//   a_i, b_i  4-bit addends
//   c_i       carry in
//   s_o       4-bit sum
//   c_o       carry out
module cla4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g = a_i & b_i;
        p = a_i ^ b_i;
        c[0] = c_i;
        c[1] = g[0] | (p[0] & c_i);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_i);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c_i);
        s_o = p ^ c[3:0];
        c_o = c[4];
    end

endmodule

// File: rtl/sub_stage.sv
// sub_stage: one pipeline stage of the subtractor. Adds the lowest group of
// the remaining operand bits with the incoming carry, places the 4 result
// bits at this stage's group position, and shifts the remaining operand
// bits down by one group for the next stage.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset, clears the stage register
//   advance_i  pipeline advance; the register holds when low
//   prev_i     record from the previous stage (or the input for stage 0)
//   stage_o    registered record of this stage
module sub_stage
    import adder_pkg::*;
#(
    parameter int GROUP_IDX = 0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   advance_i,
    input  stage_t prev_i,
    output stage_t stage_o
);

    logic [GROUP_W-1:0] grp_sum;
    logic               grp_cout;
    stage_t             stage_d;
    stage_t             stage_q;

    cla4 u_cla4 (
        .a_i (prev_i.a_rem[GROUP_W-1:0]),
        .b_i (prev_i.nb_rem[GROUP_W-1:0]),
        .c_i (prev_i.carry),
        .s_o (grp_sum),
        .c_o (grp_cout)
    );

    // valid and the operand MSBs pass through unchanged; an invalid record
    // still flows so bubbles move at the same rate as data.
    always_comb begin
        stage_d        = prev_i;
        stage_d.carry  = grp_cout;
        stage_d.sum[GROUP_IDX*GROUP_W +: GROUP_W] = grp_sum;
        stage_d.a_rem  = prev_i.a_rem >> GROUP_W;
        stage_d.nb_rem = prev_i.nb_rem >> GROUP_W;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else if (advance_i) begin
            stage_q <= stage_d;
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/pipelined_subtractor.sv
// pipelined_subtractor: streaming WIDTH-bit subtractor, D = A + ~B + 1,
// built from one 4-bit carry-lookahead group per pipeline stage with the
// carry registered between stages. Latency is WIDTH/4 cycles and one result
// can be produced every cycle.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready = !out_valid || out_ready, independent of in_valid; when it is
// low every stage and the output register hold, and diffOUT/borrow/ovf stay
// stable while out_valid && !out_ready.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_ready   input handshake
//   operA, operB         minuend, subtrahend (WIDTH bits)
//   out_valid, out_ready output handshake
//   diffOUT              A - B modulo 2^WIDTH
//   borrow               1 when A < B unsigned
//   ovf                  signed overflow of A - B
module pipelined_subtractor
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operA,
    input  logic [WIDTH-1:0] operB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diffOUT,
    output logic             borrow,
    output logic             ovf
);

    localparam int STAGES = stages_for(WIDTH);

    if (((WIDTH % GROUP_W) != 0) || (WIDTH < GROUP_W) || (WIDTH > MAX_W)) begin : g_bad_width
        $error("pipelined_subtractor: WIDTH must be a multiple of 4 in [4, 64]");
    end

    logic             advance;
    stage_t           stage_in;
    stage_t           stage_out [STAGES];
    stage_t           last;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] diff_d, diff_q;
    logic             borrow_d, borrow_q;
    logic             ovf_d, ovf_q;
    logic             unused_tail;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    // The +1 of two's-complement negation enters as stage 0's carry-in.
    always_comb begin
        stage_in        = '0;
        stage_in.valid  = in_valid;
        stage_in.carry  = 1'b1;
        stage_in.a_msb  = operA[WIDTH-1];
        stage_in.b_msb  = operB[WIDTH-1];
        stage_in.a_rem  = MAX_W'(operA);
        stage_in.nb_rem = MAX_W'(~operB);
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            sub_stage #(.GROUP_IDX(k)) u_stage (
                .clk       (clk),
                .rst       (rst),
                .advance_i (advance),
                .prev_i    (stage_in),
                .stage_o   (stage_out[k])
            );
        end else begin : g_next
            sub_stage #(.GROUP_IDX(k)) u_stage (
                .clk       (clk),
                .rst       (rst),
                .advance_i (advance),
                .prev_i    (stage_out[k-1]),
                .stage_o   (stage_out[k])
            );
        end
    end

    assign last = stage_out[STAGES-1];

    // Operand bits are fully consumed by the last stage and sum bits above
    // WIDTH are always zero.
    assign unused_tail = ^{last.a_rem, last.nb_rem, last.sum};

    // Result fields only load from a valid record, so a bubble leaves the
    // previous result visible (with out_valid low) instead of garbage.
    always_comb begin
        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        ovf_d       = ovf_q;
        if (advance) begin
            out_valid_d = last.valid;
            if (last.valid) begin
                diff_d   = last.sum[WIDTH-1:0];
                borrow_d = ~last.carry;
                ovf_d    = (last.a_msb != last.b_msb) &&
                           (last.sum[WIDTH-1] != last.a_msb);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign diffOUT   = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_subtractor.sv
module tb_pipelined_subtractor;

    localparam int W   = 16;
    localparam int LAT = W / 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] operA;
    logic [W-1:0] operB;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diffOUT;
    logic         borrow;
    logic         ovf;

    pipelined_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operA     (operA),
        .operB     (operB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diffOUT   (diffOUT),
        .borrow    (borrow),
        .ovf       (ovf)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Result packed as {borrow, ovf, diff}.
    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa, sb, sd, smax, smin;
        logic [W-1:0] d;
        logic         br, of;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        sd   = sa - sb;
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        d    = a - b;
        br   = (a < b);
        of   = (sd > smax) || (sd < smin);
        return {br, of, d};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [W+1:0] exp_q[$];
    logic         mon_en = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W+1:0] prev_out;
    logic [W+1:0] exp_v;
    int           cyc = 0;
    int           pops_seen = 0;
    int           first_pop = -1;
    int           last_pop = -1;

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            check("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
            if (prev_stall) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_stable", {14'd0, borrow, ovf, diffOUT}, {14'd0, prev_out});
            end
            if (rst) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (in_valid && in_ready)
                    exp_q.push_back(ref_sub(operA, operB));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", {31'd0, out_valid}, 32'd0);
                    end else begin
                        exp_v = exp_q.pop_front();
                        check("stream_result", {14'd0, borrow, ovf, diffOUT}, {14'd0, exp_v});
                        pops_seen++;
                        if (first_pop < 0) first_pop = cyc;
                        last_pop = cyc;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_out   = {borrow, ovf, diffOUT};
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        logic acc;
        acc      = 1'b0;
        operA    = a;
        operB    = b;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            out_ready = 1'($urandom_range(0, 1));
        end
        check("push_accept", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W+1:0] exp);
        int lat;
        out_ready = 1'b1;
        operA     = a;
        operB     = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        check({tag, "_lat"}, lat, LAT);
        check(tag, {14'd0, borrow, ovf, diffOUT}, {14'd0, exp});
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        operA     = '0;
        operB     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_diff", {16'd0, diffOUT}, 32'd0);
        check("rst_borrow", {31'd0, borrow}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        mon_en = 1'b1;

        // Directed cases: {borrow, ovf, diff}
        directed("basic",      16'h0005, 16'h0003, {1'b0, 1'b0, 16'h0002});
        directed("borrow",     16'h0003, 16'h0005, {1'b1, 1'b0, 16'hFFFE});
        directed("zero",       16'h0000, 16'h0000, {1'b0, 1'b0, 16'h0000});
        directed("ovf_neg",    16'h8000, 16'h0001, {1'b0, 1'b1, 16'h7FFF});
        directed("ovf_pos",    16'h7FFF, 16'hFFFF, {1'b1, 1'b1, 16'h8000});
        directed("ripple",     16'h0000, 16'h0001, {1'b1, 1'b0, 16'hFFFF});
        drain();

        // Random stream with backpressure
        for (int i = 0; i < 100; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            push(W'($urandom), W'($urandom));
        end
        drain();

        // Throughput: out_ready held high, back-to-back inputs
        pops_seen = 0;
        first_pop = -1;
        last_pop  = -1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) push(W'($urandom), W'($urandom));
        repeat (LAT + 4) @(posedge clk);
        #1;
        check("tput_count", pops_seen, 20);
        check("tput_span", last_pop - first_pop, 19);
        drain();

        // Reset mid-flight: two accepted, third presented with rst
        out_ready = 1'b1;
        operA = W'($urandom); operB = W'($urandom); in_valid = 1'b1;
        @(posedge clk); #1;
        operA = W'($urandom); operB = W'($urandom);
        @(posedge clk); #1;
        operA = W'($urandom); operB = W'($urandom); rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk);
            #1;
            check("flush_valid", {31'd0, out_valid}, 32'd0);
            check("flush_diff", {16'd0, diffOUT}, 32'd0);
        end
        directed("after_rst", 16'h1234, 16'h0234, {1'b0, 1'b0, 16'h1000});
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
